// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin fetch/data arbiter onto a single-port memory bus
//            with wait-state tracking and hung-bus timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic              i_ready,
  output logic [DATA_W-1:0] instr,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              bus_read,
  output logic              bus_write,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_be,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_busy
);

  localparam int c_cnt_w = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [c_cnt_w-1:0] c_last_wait = c_cnt_w'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DATA  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_last_data;
  logic [c_cnt_w-1:0]  r_wait_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [3:0]          r_be;
  logic                r_write;
  logic                r_src_data;
  logic                r_err;

  logic w_d_req;
  logic w_bus_phase;
  logic w_timeout;
  logic w_grant;
  logic w_grant_data;
  logic w_done;
  logic w_abort;

  assign w_d_req     = d_read | d_write;
  assign w_bus_phase = (r_state == S_FETCH) || (r_state == S_DATA);
  // Abort fires on the busy edge that would bring the count up to MAX_WAIT
  assign w_timeout   = (MAX_WAIT != 0) && (r_wait_cnt == c_last_wait);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_grant_data = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req || w_d_req) begin
          w_grant      = 1'b1;
          w_grant_data = w_d_req && (!i_req || !r_last_data);
          w_next_state = w_grant_data ? S_DATA : S_FETCH;
        end
      end
      S_FETCH, S_DATA: begin
        if (!bus_busy) begin
          w_done       = 1'b1;
          w_next_state = S_RESP;
        end else if (w_timeout) begin
          w_abort      = 1'b1;
          w_next_state = S_RESP;
        end
      end
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_last_data <= 1'b1;
      r_wait_cnt  <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_write     <= 1'b0;
      r_src_data  <= 1'b0;
      r_err       <= 1'b0;
      instr       <= '0;
      d_rdata     <= '0;
    end else begin
      if (w_grant) begin
        r_src_data <= w_grant_data;
        r_write    <= w_grant_data && d_write;
        r_addr     <= w_grant_data ? d_addr : i_addr;
        r_wdata    <= d_wdata;
        r_be       <= (w_grant_data && d_write) ? d_be : 4'hF;
      end
      if (w_bus_phase) begin
        if (w_done || w_abort) begin
          r_wait_cnt  <= '0;
          r_last_data <= r_src_data;
          r_err       <= w_abort;
        end else if (r_wait_cnt != '1) begin
          r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
        end
        if (w_done && !r_write) begin
          if (r_src_data) d_rdata <= bus_rdata;
          else            instr   <= bus_rdata;
        end
      end
    end
  end

  assign bus_read  = w_bus_phase && !r_write;
  assign bus_write = w_bus_phase && r_write;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign bus_be    = r_be;
  assign i_ready   = (r_state == S_RESP) && !r_src_data;
  assign d_ready   = (r_state == S_RESP) && r_src_data;
  assign err       = (r_state == S_RESP) && r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed plus randomized checks of mem_arbiter against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        i_ready;
  logic [31:0] instr;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        err;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata = '0;
  logic        bus_busy = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: which source went last, and the last good read data
  bit          exp_last_data = 1'b1;
  logic [31:0] exp_instr = '0;
  logic [31:0] exp_drdata = '0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .nrst(nrst),
    .i_req(i_req), .i_addr(i_addr),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_be(d_be),
    .i_ready(i_ready), .instr(instr),
    .d_ready(d_ready), .d_rdata(d_rdata), .err(err),
    .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_rdata(bus_rdata), .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".bus_read"}, bus_read, 0);
    chk({tag, ".bus_write"}, bus_write, 0);
    chk({tag, ".i_ready"}, i_ready, 0);
    chk({tag, ".d_ready"}, d_ready, 0);
    chk({tag, ".err"}, err, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_quiet(tag);
    chk({tag, ".instr"}, instr, 0);
    chk({tag, ".d_rdata"}, d_rdata, 0);
    chk({tag, ".bus_addr"}, bus_addr, 0);
    chk({tag, ".bus_wdata"}, bus_wdata, 0);
    chk({tag, ".bus_be"}, bus_be, 0);
  endtask

  function automatic bit pick_data();
    bit dreq = d_read || d_write;
    return dreq && (!i_req || !exp_last_data);
  endfunction

  // Entered at a negedge in IDLE with requests applied; returns at a negedge in IDLE
  task automatic serve(input bit is_data, input int busy_n, input logic [31:0] rdata, input string tag);
    bit          wr     = is_data && d_write;
    logic [31:0] addr   = is_data ? d_addr : i_addr;
    logic [31:0] wd     = d_wdata;
    logic [3:0]  be     = wr ? d_be : 4'hF;
    bit          abort  = (busy_n >= MW);
    int          strobe = abort ? MW : busy_n + 1;
    @(posedge clk); @(negedge clk);
    for (int c = 0; c < strobe; c++) begin
      bus_busy  = (c < busy_n);
      bus_rdata = rdata;
      chk({tag, ".bus_read"}, bus_read, !wr);
      chk({tag, ".bus_write"}, bus_write, wr);
      chk({tag, ".bus_addr"}, bus_addr, addr);
      chk({tag, ".bus_be"}, bus_be, be);
      if (wr) chk({tag, ".bus_wdata"}, bus_wdata, wd);
      chk({tag, ".i_ready_early"}, i_ready, 0);
      chk({tag, ".d_ready_early"}, d_ready, 0);
      if (c == 0) begin
        // Core-side changes after the grant must not reach the bus
        if (is_data) begin
          d_addr = ~d_addr; d_wdata = ~d_wdata; d_be = ~d_be;
        end else begin
          i_addr = ~i_addr;
        end
      end
      @(posedge clk); @(negedge clk);
    end
    bus_busy  = 1'b0;
    bus_rdata = $urandom;
    if (!abort && !wr) begin
      if (is_data) exp_drdata = rdata;
      else         exp_instr  = rdata;
    end
    exp_last_data = is_data;
    chk({tag, ".i_ready"}, i_ready, !is_data);
    chk({tag, ".d_ready"}, d_ready, is_data);
    chk({tag, ".err"}, err, abort);
    chk({tag, ".resp_strobe"}, bus_read | bus_write, 0);
    chk({tag, ".instr"}, instr, exp_instr);
    chk({tag, ".d_rdata"}, d_rdata, exp_drdata);
    if (is_data) begin d_read = 1'b0; d_write = 1'b0; end
    else         i_req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk_quiet({tag, ".after"});
  endtask

  task automatic serve_all(input string tag);
    while (i_req || d_read || d_write)
      serve(pick_data(), $urandom_range(0, 6), $urandom, tag);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    nrst = 1'b1;
    @(negedge clk);
    chk_all_zero("idle");

    // Reset mid-transaction
    i_req = 1'b1; i_addr = 32'h0000_0040;
    @(posedge clk); @(negedge clk);
    bus_busy = 1'b1;
    chk("rst_mid.bus_read_before", bus_read, 1);
    #2 nrst = 1'b0;
    #1 chk("rst_mid.bus_read_async", bus_read, 0);
    chk("rst_mid.i_ready", i_ready, 0);
    i_req = 1'b0; bus_busy = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_mid.held");
    nrst = 1'b1;
    exp_last_data = 1'b1; exp_instr = '0; exp_drdata = '0;
    @(posedge clk); @(negedge clk);
    chk_all_zero("rst_mid.released");

    // Fetch with no waits
    i_req = 1'b1; i_addr = 32'h0000_0004;
    serve(1'b0, 0, 32'h3E80_0093, "fetch0");
    chk("fetch0.instr_val", instr, 32'h3E80_0093);

    // Load with 3 busy cycles
    d_read = 1'b1; d_addr = 32'h0000_0100;
    serve(1'b1, 3, 32'hDEAD_BEEF, "load3");
    chk("load3.d_rdata_val", d_rdata, 32'hDEAD_BEEF);

    // Simultaneous, last grant was data: fetch first
    i_req = 1'b1; i_addr = 32'h0000_0008;
    d_write = 1'b1; d_addr = 32'h0000_0200; d_wdata = 32'hCAFE_F00D; d_be = 4'h3;
    serve(1'b0, 1, 32'h0010_0113, "both_ld.fetch");
    serve(1'b1, 0, 32'h1234_5678, "both_ld.store");

    // Simultaneous, last grant was fetch: store first
    i_req = 1'b1; i_addr = 32'h0000_000C;
    serve(1'b0, 0, 32'h0020_0193, "solo_fetch");
    i_req = 1'b1; i_addr = 32'h0000_0010;
    d_write = 1'b1; d_addr = 32'h0000_0300; d_wdata = 32'h0BAD_F00D; d_be = 4'hC;
    serve(1'b1, 2, 32'h5555_AAAA, "both_lf.store");
    serve(1'b0, 0, 32'h0030_0213, "both_lf.fetch");

    // Timeout on a load: stuck busy
    d_read = 1'b1; d_addr = 32'h0000_0400;
    serve(1'b1, MW, 32'hFFFF_0000, "timeout");
    chk("timeout.d_rdata_kept", d_rdata, 32'hDEAD_BEEF);

    // Read/write conflict behaves as a write
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h0000_0500;
    d_wdata = 32'h1357_9BDF; d_be = 4'hF;
    serve(1'b1, 1, 32'h2468_ACE0, "conflict");

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      i_req   = $urandom_range(0, 1);
      d_read  = $urandom_range(0, 1);
      d_write = ($urandom_range(0, 3) == 0);
      i_addr  = $urandom; d_addr = $urandom; d_wdata = $urandom;
      d_be    = 4'($urandom);
      if (!(i_req || d_read || d_write)) begin
        @(posedge clk); @(negedge clk);
        chk_quiet("rand.idle");
      end else begin
        serve_all("rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
